register_file_scoreboard: RTL and testbench

REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

---
 rtl/register_file_scoreboard.sv | 92 +++++++++
 tb/tb_register_file_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// Register file with a per-register busy bit (scoreboard), two combinational read ports, optional write bypass.
// Writes/reserves take effect on the clock edge; busy_count is registered; no backpressure, always accepts.
module register_file_scoreboard #(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 2,
  parameter int BYPASS      = 1,
  parameter int ZERO_REG    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] read_index_a,
  input  logic [INDEX_WIDTH-1:0] read_index_b,
  output logic [DATA_WIDTH-1:0]  read_data_a,
  output logic [DATA_WIDTH-1:0]  read_data_b,
  output logic                   read_busy_a,
  output logic                   read_busy_b,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic                   write_enable,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic [INDEX_WIDTH-1:0] reserve_index,
  input  logic                   reserve_enable,
  output logic [INDEX_WIDTH:0]   busy_count
);
  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       busy_next;
  logic [INDEX_WIDTH:0]   count_next;
  logic                   write_ok;
  logic                   reserve_ok;
  logic                   bypass_busy;

  logic [INDEX_WIDTH-1:0] rd_index [2];
  logic [DATA_WIDTH-1:0]  rd_data  [2];
  logic                   rd_busy  [2];

  assign write_ok    = write_enable && !(ZERO_REG != 0 && write_index == '0);
  assign reserve_ok  = reserve_enable && !(ZERO_REG != 0 && reserve_index == '0);
  assign bypass_busy = reserve_enable && (reserve_index == write_index);

  // Reserve is applied after the write clear so it wins on a shared index.
  always_comb begin
    busy_next = busy;
    if (write_ok) busy_next[write_index] = 1'b0;
    if (reserve_ok) busy_next[reserve_index] = 1'b1;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{INDEX_WIDTH{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (write_ok) regs[write_index] <= write_data;
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  assign rd_index[0] = read_index_a;
  assign rd_index[1] = read_index_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (reset) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if (ZERO_REG != 0 && rd_index[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if (BYPASS != 0 && write_enable && rd_index[p] == write_index) begin
        rd_data[p] = write_data;
        rd_busy[p] = bypass_busy;
      end else begin
        rd_data[p] = regs[rd_index[p]];
        rd_busy[p] = busy[rd_index[p]];
      end
    end
  end

  assign read_data_a = rd_data[0];
  assign read_data_b = rd_data[1];
  assign read_busy_a = rd_busy[0];
  assign read_busy_b = rd_busy[1];
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed vector bench: main instance uses defaults (bypass on, no zero register);
// a second instance with ZERO_REG=1, BYPASS=0 shares the inputs and is checked in a hand sequence.
module tb_register_file_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  read_index_a, read_index_b, write_index, reserve_index;
  logic        write_enable, reserve_enable;
  logic [15:0] write_data;
  logic [15:0] read_data_a, read_data_b, z_data_a, z_data_b;
  logic        read_busy_a, read_busy_b, z_busy_a, z_busy_b;
  logic [2:0]  busy_count, z_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  register_file_scoreboard dut (
    .clk(clk), .reset(reset),
    .read_index_a(read_index_a), .read_index_b(read_index_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .read_busy_a(read_busy_a), .read_busy_b(read_busy_b),
    .write_index(write_index), .write_enable(write_enable), .write_data(write_data),
    .reserve_index(reserve_index), .reserve_enable(reserve_enable),
    .busy_count(busy_count)
  );

  register_file_scoreboard #(.DATA_WIDTH(16), .INDEX_WIDTH(2), .BYPASS(0), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .read_index_a(read_index_a), .read_index_b(read_index_b),
    .read_data_a(z_data_a), .read_data_b(z_data_b),
    .read_busy_a(z_busy_a), .read_busy_b(z_busy_b),
    .write_index(write_index), .write_enable(write_enable), .write_data(write_data),
    .reserve_index(reserve_index), .reserve_enable(reserve_enable),
    .busy_count(z_count)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  ra, rb;
    logic        we;
    logic [1:0]  wi;
    logic [15:0] wd;
    logic        rse;
    logic [1:0]  rsi;
    logic [15:0] da;
    logic        ba;
    logic [15:0] db;
    logic        bb;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic [1:0] ra, input logic [1:0] rb,
                              input logic we, input logic [1:0] wi, input logic [15:0] wd,
                              input logic rse, input logic [1:0] rsi,
                              input logic [15:0] da, input logic ba,
                              input logic [15:0] db, input logic bb, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.ra = ra; v.rb = rb; v.we = we; v.wi = wi; v.wd = wd;
    v.rse = rse; v.rsi = rsi; v.da = da; v.ba = ba; v.db = db; v.bb = bb; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    read_index_a   = v.ra;
    read_index_b   = v.rb;
    write_enable   = v.we;
    write_index    = v.wi;
    write_data     = v.wd;
    reserve_enable = v.rse;
    reserve_index  = v.rsi;
  endtask

  initial begin
    vec_t idle;
    //               rst ra rb  we wi wd        rse rsi  da        ba  db        bb  cnt
    vecs[0]  = mk(1, 0, 1, 1, 0, 16'hFFFF, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(0, 2, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[3]  = mk(0, 2, 0, 1, 2, 16'hBEEF, 0, 0, 16'hBEEF, 0, 16'h0000, 0, 0);
    vecs[4]  = mk(0, 2, 2, 0, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 16'hBEEF, 0, 0);
    vecs[5]  = mk(0, 3, 2, 0, 0, 16'h0000, 1, 3, 16'h0000, 0, 16'hBEEF, 0, 1);
    vecs[6]  = mk(0, 3, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 1);
    vecs[7]  = mk(0, 3, 2, 1, 3, 16'h1234, 0, 0, 16'h1234, 0, 16'hBEEF, 0, 0);
    vecs[8]  = mk(0, 3, 1, 0, 0, 16'h0000, 0, 0, 16'h1234, 0, 16'h0000, 0, 0);
    vecs[9]  = mk(0, 1, 1, 1, 1, 16'h00AA, 1, 1, 16'h00AA, 1, 16'h00AA, 1, 1);
    vecs[10] = mk(0, 1, 3, 0, 0, 16'h0000, 0, 0, 16'h00AA, 1, 16'h1234, 0, 1);
    vecs[11] = mk(0, 1, 0, 0, 0, 16'h0000, 1, 1, 16'h00AA, 1, 16'h0000, 0, 1);
    vecs[12] = mk(0, 2, 0, 1, 2, 16'h5555, 1, 0, 16'h5555, 0, 16'h0000, 0, 2);
    vecs[13] = mk(0, 0, 2, 0, 0, 16'h0000, 1, 2, 16'h0000, 1, 16'h5555, 0, 3);
    vecs[14] = mk(0, 3, 2, 0, 0, 16'h0000, 1, 3, 16'h1234, 0, 16'h5555, 1, 4);
    vecs[15] = mk(0, 0, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234, 1, 4);
    vecs[16] = mk(1, 1, 3, 1, 1, 16'h7777, 1, 2, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[17] = mk(0, 1, 3, 1, 1, 16'h0005, 0, 0, 16'h0005, 0, 16'h0000, 0, 0);
    vecs[18] = mk(0, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0005, 0, 16'h0005, 0, 0);
    vecs[19] = mk(0, 3, 2, 1, 3, 16'h00C3, 1, 2, 16'h00C3, 0, 16'h0000, 0, 1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d data_a", i), {16'h0, read_data_a}, {16'h0, vecs[i].da});
      chk($sformatf("v%0d busy_a", i), {31'h0, read_busy_a}, {31'h0, vecs[i].ba});
      chk($sformatf("v%0d data_b", i), {16'h0, read_data_b}, {16'h0, vecs[i].db});
      chk($sformatf("v%0d busy_b", i), {31'h0, read_busy_b}, {31'h0, vecs[i].bb});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy_count", i), {29'h0, busy_count}, {29'h0, vecs[i].cnt});
    end

    // Zero-register instance: its state now holds reg1=0005, reg3=00C3, busy on reg2 only.
    idle = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    drive(idle);
    #2;
    chk("z pre count", {29'h0, z_count}, 32'd1);
    drive(mk(0, 0, 0, 1, 0, 16'hFFFF, 1, 0, 16'h0000, 0, 16'h0000, 0, 0));
    #2;
    chk("z idx0 same-cycle data", {16'h0, z_data_a}, 32'h0);
    chk("z idx0 same-cycle busy", {31'h0, z_busy_a}, 32'h0);
    chk("main idx0 bypass data", {16'h0, read_data_a}, 32'hFFFF);
    chk("main idx0 bypass busy", {31'h0, read_busy_a}, 32'h1);
    @(posedge clk);
    #1;
    drive(idle);
    #1;
    chk("z idx0 data after", {16'h0, z_data_a}, 32'h0);
    chk("z idx0 busy after", {31'h0, z_busy_b}, 32'h0);
    chk("z count unchanged", {29'h0, z_count}, 32'd1);
    chk("main idx0 stored data", {16'h0, read_data_a}, 32'hFFFF);
    chk("main idx0 stored busy", {31'h0, read_busy_b}, 32'h1);
    chk("main count", {29'h0, busy_count}, 32'd2);

    // Without bypass a write is invisible until after the edge.
    drive(mk(0, 3, 2, 1, 3, 16'hABCD, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
    #2;
    chk("z no-bypass old data", {16'h0, z_data_a}, 32'h00C3);
    chk("z no-bypass busy2", {31'h0, z_busy_b}, 32'h1);
    chk("main bypass new data", {16'h0, read_data_a}, 32'hABCD);
    @(posedge clk);
    #1;
    drive(idle);
    read_index_a = 2'd3;
    #1;
    chk("z no-bypass new data", {16'h0, z_data_a}, 32'hABCD);
    chk("main data after", {16'h0, read_data_a}, 32'hABCD);

    // Reset held over two edges, then normal operation on the first edge after release.
    drive(mk(1, 1, 2, 1, 2, 16'h1111, 1, 1, 16'h0000, 0, 16'h0000, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst2 count", {29'h0, busy_count}, 32'd0);
    chk("rst2 z count", {29'h0, z_count}, 32'd0);
    drive(mk(0, 1, 2, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 0, 0));
    #1;
    chk("rst2 data1", {16'h0, read_data_a}, 32'h0);
    chk("rst2 data2", {16'h0, read_data_b}, 32'h0);
    @(posedge clk);
    #1;
    drive(idle);
    read_index_a = 2'd1;
    #1;
    chk("post-rst reserve count", {29'h0, busy_count}, 32'd1);
    chk("post-rst reserve busy", {31'h0, read_busy_a}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
